serialize_words_to_bit_stream: RTL and testbench

- Parallel-to-serial front end for the single-bit sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on down_bit, which drives the detector's serial input.
- Has a one-word holding register, so consecutive words stream back-to-back with no idle gap.
- Drives a constant idle level whenever it has no data to emit.

---
 rtl/serialize_words_to_bit_stream.sv | 105 ++++++++++
 tb/tb_serialize_words_to_bit_stream.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serialize_words_to_bit_stream.sv
// Word-to-bit serializer feeding the serial sequence detectors.
// A one-word hold register lets consecutive words stream with no gap.
module serialize_words_to_bit_stream #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  output logic             down_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shifted;
  logic             hold_full;
  logic             hs;
  logic             last;

  assign hs   = up_valid && !hold_full;
  assign last = (state == SHIFT) && (bit_cnt == LAST);

  // Shift toward the emitted end; vacated bits fill with 0.
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (hs) state_nx = SHIFT;
      end
      last: begin
        if (!hold_full && !hs) state_nx = IDLE;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (state == IDLE) begin
      if (hs) begin
        shreg   <= up_data;
        bit_cnt <= '0;
      end
    end else if (last) begin
      bit_cnt <= '0;
      if (hold_full) begin
        shreg     <= hold;
        hold_full <= 1'b0;
      end else if (hs) begin
        shreg <= up_data;
      end else begin
        shreg <= shifted;
      end
    end else begin
      shreg   <= shifted;
      bit_cnt <= bit_cnt + CW'(1);
      if (hs) begin
        hold      <= up_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    up_ready   = !hold_full;
    down_valid = (state == SHIFT);
    busy       = (state == SHIFT) || hold_full;
    down_bit   = IDLE_LEVEL;
    if (state == SHIFT) begin
      down_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
  end

endmodule

// File: tb/tb_serialize_words_to_bit_stream.sv
// Serializer bench: two configurations checked against a bit-queue model.
// Model: pending bits queue; ready while at most one word of bits remains.
module tb_serialize_words_to_bit_stream;

  localparam int WA = 6;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic [WA-1:0] da = '0;
  logic [WB-1:0] db = '0;
  logic ra, dva, bita, bsya;
  logic rb, dvb, bitb, bsyb;

  serialize_words_to_bit_stream #(
    .WIDTH(WA), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst),
    .up_valid(va), .up_ready(ra), .up_data(da),
    .down_valid(dva), .down_bit(bita), .busy(bsya)
  );

  serialize_words_to_bit_stream #(
    .WIDTH(WB), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst),
    .up_valid(vb), .up_ready(rb), .up_data(db),
    .down_valid(dvb), .down_bit(bitb), .busy(bsyb)
  );

  always #5 clk = ~clk;

  bit         qa[$];
  bit         qb[$];
  logic [7:0] pa[$];
  logic [7:0] pb[$];
  bit         sa, sb;
  int         dens = 100;
  int         ntests = 0;
  int         nfail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wbit(logic [7:0] w, int width, bit msb, int i);
    return msb ? w[width-1-i] : w[i];
  endfunction

  task automatic check_outs();
    chk("a_valid", 32'(dva), 32'(qa.size() != 0));
    chk("a_bit", 32'(bita), 32'(qa.size() != 0 ? qa[0] : 1'b0));
    chk("a_ready", 32'(ra), 32'(qa.size() <= WA));
    chk("a_busy", 32'(bsya), 32'(qa.size() != 0));
    chk("b_valid", 32'(dvb), 32'(qb.size() != 0));
    chk("b_bit", 32'(bitb), 32'(qb.size() != 0 ? qb[0] : 1'b1));
    chk("b_ready", 32'(rb), 32'(qb.size() <= WB));
    chk("b_busy", 32'(bsyb), 32'(qb.size() != 0));
  endtask

  task automatic step();
    bit hsa, hsb;
    @(negedge clk);
    check_outs();
    if (!sa && pa.size() != 0) sa = ($urandom_range(99) < dens);
    if (!sb && pb.size() != 0) sb = ($urandom_range(99) < dens);
    va = sa;
    vb = sb;
    da = sa ? pa[0][WA-1:0] : WA'($urandom);
    db = sb ? pb[0][WB-1:0] : WB'($urandom);
    hsa = va && (qa.size() <= WA);
    hsb = vb && (qb.size() <= WB);
    @(posedge clk);
    if (qa.size() != 0) void'(qa.pop_front());
    if (qb.size() != 0) void'(qb.pop_front());
    if (hsa) begin
      for (int i = 0; i < WA; i++) qa.push_back(wbit(pa[0], WA, 1'b1, i));
      void'(pa.pop_front());
      sa = 1'b0;
    end
    if (hsb) begin
      for (int i = 0; i < WB; i++) qb.push_back(wbit(pb[0], WB, 1'b0, i));
      void'(pb.pop_front());
      sb = 1'b0;
    end
  endtask

  task automatic feed_random();
    if (pa.size() < 3 && $urandom_range(99) < 30) pa.push_back(8'($urandom));
    if (pb.size() < 3 && $urandom_range(99) < 30) pb.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    repeat (3) step();
    #2 rst = 1'b0;

    repeat (20) step();

    dens = 100;
    pa.push_back(8'b0011_0011);
    pb.push_back(8'h0A);
    pb.push_back(8'h05);
    pb.push_back(8'h0F);
    repeat (20) step();

    pb.push_back(8'h03);
    pa.push_back(8'b0000_0101);
    n = 0;
    while (n < 20 && !(qb.size() == 1 && pb.size() == 0)) begin
      step();
      n++;
    end
    chk("b_lastbit_setup", 32'(qb.size()), 32'd1);
    pb.push_back(8'h09);
    repeat (10) step();

    dens = 60;
    repeat (400) begin
      feed_random();
      step();
    end

    dens = 100;
    n = 0;
    while (n < 50 && qa.size() <= WA) begin
      if (pa.size() < 2) pa.push_back(8'hC3);
      step();
      n++;
    end
    chk("rst_setup_hold", 32'(qa.size() > WA), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    va = 1'b0;
    vb = 1'b0;
    #1;
    chk("rst_a_valid", 32'(dva), 32'd0);
    chk("rst_a_bit", 32'(bita), 32'd0);
    chk("rst_a_ready", 32'(ra), 32'd1);
    chk("rst_a_busy", 32'(bsya), 32'd0);
    chk("rst_b_valid", 32'(dvb), 32'd0);
    chk("rst_b_bit", 32'(bitb), 32'd1);
    chk("rst_b_ready", 32'(rb), 32'd1);
    chk("rst_b_busy", 32'(bsyb), 32'd0);
    qa.delete();
    qb.delete();
    pa.delete();
    pb.delete();
    sa = 1'b0;
    sb = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) step();

    dens = 60;
    repeat (200) begin
      feed_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
